// File: rtl/csa_pkg.sv
// Shared constants and helpers for the pipelined carry-skip adder.
package csa_pkg;

  localparam logic SUB_MODE = 1'b1;

  // Number of skip groups, which is also the number of pipeline stages.
  function automatic int unsigned nblk(input int unsigned width, input int unsigned block);
    return (block == 0) ? 1 : width / block;
  endfunction

endpackage

// File: rtl/csa_skip_group.sv
// One BLOCK-bit carry-skip group: ripple sum, propagate-AND reduction and skip mux.
module csa_skip_group #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             p
);

  logic [BLOCK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
  end

  assign p  = &(a ^ b);
  // When every bit propagates, the incoming carry bypasses the ripple chain.
  assign co = p ? ci : c[BLOCK];

endmodule

// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder/subtractor, one skip group resolved per stage.
// Optional signed-overflow output enabled by defining CSA_OVERFLOW_EN.
module carry_skip_adder_pipe
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NBLK = nblk(WIDTH, BLOCK);

  if (BLOCK < 1) begin : g_bad_block
    $fatal(1, "carry_skip_adder_pipe: BLOCK must be at least 1");
  end else if (WIDTH % BLOCK != 0) begin : g_bad_width
    $fatal(1, "carry_skip_adder_pipe: WIDTH must be a multiple of BLOCK");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
`ifdef CSA_OVERFLOW_EN
    logic             ovf;
`endif
  } stage_t;

  stage_t stage_q [NBLK];
  stage_t in_stage;
  logic   advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Map subtraction onto the adder core; bubbles carry all-zero data.
  always_comb begin
    in_stage = '0;
    if (in_valid) begin
      in_stage.valid = 1'b1;
      in_stage.a     = a;
      in_stage.b     = (sub == SUB_MODE) ? ~b : b;
      in_stage.carry = (sub == SUB_MODE) ? ~cin : cin;
    end
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    stage_t           src;
    stage_t           stage_d;
    logic [BLOCK-1:0] grp_s;
    logic             grp_co;
    logic             unused_p;

    if (k == 0) begin : g_first
      assign src = in_stage;
    end else begin : g_next
      assign src = stage_q[k-1];
    end

    csa_skip_group #(.BLOCK(BLOCK)) u_grp (
      .a  (src.a[k*BLOCK +: BLOCK]),
      .b  (src.b[k*BLOCK +: BLOCK]),
      .ci (src.carry),
      .s  (grp_s),
      .co (grp_co),
      .p  (unused_p)
    );

    always_comb begin
      stage_d                       = src;
      stage_d.a[k*BLOCK +: BLOCK]   = '0;
      stage_d.b[k*BLOCK +: BLOCK]   = '0;
      stage_d.sum[k*BLOCK +: BLOCK] = grp_s;
      stage_d.carry                 = grp_co;
`ifdef CSA_OVERFLOW_EN
      // Carry into the MSB is recovered from the MSB sum bit; meaningful in the last stage only.
      stage_d.ovf = (src.a[WIDTH-1] ^ src.b[WIDTH-1] ^ grp_s[BLOCK-1]) ^ grp_co;
`endif
      if (!src.valid) begin
        stage_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q[k] <= '0;
      end else if (advance) begin
        stage_q[k] <= stage_d;
      end
    end
  end

  assign out_valid = stage_q[NBLK-1].valid;
  assign sum       = stage_q[NBLK-1].sum;
  assign cout      = stage_q[NBLK-1].carry;
`ifdef CSA_OVERFLOW_EN
  assign ovf       = stage_q[NBLK-1].ovf;
`endif

  logic unused_tail;
  assign unused_tail = ^{stage_q[NBLK-1].a, stage_q[NBLK-1].b};

endmodule
